// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered 1-bit framebuffer.
package fb_pkg;

  function automatic int unsigned fb_addr_width(input int unsigned h, input int unsigned v);
    return $clog2(h * v);
  endfunction

  localparam int unsigned FB_BANKS = 2;
  localparam int unsigned FB_H     = 640;
  localparam int unsigned FB_V     = 480;
  localparam int unsigned FB_AW    = fb_addr_width(FB_H, FB_V);

  typedef enum logic {FB_IDLE, FB_SWAP} fb_swap_state_t;

endpackage

// File: rtl/fb_double_buffer_if.sv
// Renderer/scanout bus of the framebuffer. Stats signals exist only with
// FB_DOUBLE_BUFFER_STATS_EN defined.
interface fb_double_buffer_if #(
  parameter int unsigned ADDR_WIDTH = fb_pkg::FB_AW
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_data;
  logic                  render_done;
  logic                  frame_start;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;
  logic                  swap;
  logic                  front_sel;
`ifdef FB_DOUBLE_BUFFER_STATS_EN
  logic [15:0]           missed_frames;
  logic [7:0]            last_swap_frame_gap;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, render_done, frame_start, rd_en, rd_addr,
    input  rd_data, swap, front_sel
`ifdef FB_DOUBLE_BUFFER_STATS_EN
    , input missed_frames, last_swap_frame_gap
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, render_done, frame_start, rd_en, rd_addr,
    output rd_data, swap, front_sel
`ifdef FB_DOUBLE_BUFFER_STATS_EN
    , output missed_frames, last_swap_frame_gap
`endif
  );

endinterface

// File: rtl/fb_bank.sv
// One 1-bit simple-dual-port framebuffer bank: sync write, registered read,
// out-of-range addresses ignored on write and read as 0.
module fb_bank #(
  parameter int unsigned DEPTH      = 307200,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                  i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_data
);

  logic r_mem [DEPTH];
  logic r_q;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < DEPTH);
  assign w_rd_ok = 32'(i_rd_addr) < DEPTH;

  // RAM array carries no reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_q <= 1'b0;
    else if (i_rd_en) r_q <= w_rd_ok ? r_mem[i_rd_addr] : 1'b0;
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/fb_double_buffer.sv
// Double-buffered 1-bit framebuffer: renderer writes the back bank, scanout
// reads the front bank, banks swap at frame_start when the renderer is done.
// Optional stats outputs enabled by FB_DOUBLE_BUFFER_STATS_EN.
module fb_double_buffer
  import fb_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480
) (
  input  logic         clk,
  input  logic         rst,
  fb_double_buffer_if.slave bus
);

  localparam int unsigned DEPTH      = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned ADDR_WIDTH = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);

  fb_swap_state_t        r_state;
  fb_swap_state_t        w_state_nxt;
  logic                  w_swap_go;
  logic                  w_fs_accept;
  logic                  r_swap;
  logic                  r_front_sel;
  logic                  r_rd_sel;
  logic [FB_BANKS-1:0]   w_bank_we;
  logic [FB_BANKS-1:0]   w_bank_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Swap only on a frame_start that finds the renderer done; SWAP lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_swap_go   = 1'b0;
    w_fs_accept = 1'b0;
    case (r_state)
      FB_IDLE: begin
        w_fs_accept = bus.frame_start;
        if (bus.frame_start && bus.render_done) begin
          w_state_nxt = FB_SWAP;
          w_swap_go   = 1'b1;
        end
      end
      FB_SWAP: w_state_nxt = FB_IDLE;
      default: w_state_nxt = FB_IDLE;
    endcase
  end

  // front_sel flips on the same edge that raises swap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swap      <= 1'b0;
      r_front_sel <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_swap <= w_swap_go;
      if (w_swap_go)  r_front_sel <= ~r_front_sel;
      if (bus.rd_en)  r_rd_sel    <= r_front_sel;
    end
  end

  always_comb begin
    w_bank_we = '0;
    if (bus.wr_en && !rst) w_bank_we[~r_front_sel] = 1'b1;
  end

  for (genvar b = 0; b < FB_BANKS; b++) begin : g_bank
    fb_bank #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_bank_we[b]),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_rd_en   (bus.rd_en),
      .i_rd_addr (bus.rd_addr),
      .o_rd_data (w_bank_q[b])
    );
  end

  assign bus.rd_data   = w_bank_q[r_rd_sel];
  assign bus.swap      = r_swap;
  assign bus.front_sel = r_front_sel;

`ifdef FB_DOUBLE_BUFFER_STATS_EN
  logic [15:0] r_missed;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_last_gap;
  logic [7:0]  w_gap_inc;

  assign w_gap_inc = (r_gap_cnt == 8'hFF) ? 8'hFF : r_gap_cnt + 8'd1;

  // Gap counts accepted frame_starts since the previous swap, including the swapping one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_missed   <= 16'd0;
      r_gap_cnt  <= 8'd0;
      r_last_gap <= 8'd0;
    end else if (w_fs_accept) begin
      if (!bus.render_done && r_missed != 16'hFFFF) r_missed <= r_missed + 16'd1;
      if (w_swap_go) begin
        r_last_gap <= w_gap_inc;
        r_gap_cnt  <= 8'd0;
      end else begin
        r_gap_cnt  <= w_gap_inc;
      end
    end
  end

  assign bus.missed_frames       = r_missed;
  assign bus.last_swap_frame_gap = r_last_gap;
`endif

endmodule
